// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO registers.
// Results are written back only at the end of the busy window. Operands are latched when the operation is accepted.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_t      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic [1:0]  r_op, w_op_next;
    logic [31:0] r_a, w_a_next;
    logic [31:0] r_b, w_b_next;
    logic [31:0] r_hi, w_hi_next;
    logic [31:0] r_lo, w_lo_next;
    logic        r_busy, w_busy_next;

    // Sign-extended and zero-extended operands give the signed and unsigned 64-bit products.
    logic [63:0] w_prod_s, w_prod_u;
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'b0, r_a} * {32'b0, r_b};

    // One unsigned divider serves both div and divu.
    // For div it works on magnitudes and the signs are applied afterwards, which also handles 0x80000000 / -1.
    logic        w_signed_div;
    logic [31:0] w_dvd, w_dvs, w_q, w_r, w_div_q, w_div_r;
    logic        w_div_zero;
    assign w_signed_div = (r_op == 2'd2);
    assign w_dvd   = (w_signed_div && r_a[31]) ? (32'd0 - r_a) : r_a;
    assign w_dvs   = (w_signed_div && r_b[31]) ? (32'd0 - r_b) : r_b;
    assign w_q     = w_dvd / w_dvs;
    assign w_r     = w_dvd % w_dvs;
    assign w_div_q = (w_signed_div && (r_a[31] ^ r_b[31])) ? (32'd0 - w_q) : w_q;
    assign w_div_r = (w_signed_div && r_a[31]) ? (32'd0 - w_r) : w_r;
    assign w_div_zero = (r_b == 32'd0);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_op_next    = r_op;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_busy_next  = r_busy;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (md_op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            w_op_next    = md_op[1:0];
                            w_a_next     = rs_val;
                            w_b_next     = rt_val;
                            w_cnt_next   = md_op[1] ? DIV_N : MULT_N;
                            w_busy_next  = 1'b1;
                            w_state_next = S_BUSY;
                        end
                        3'd4:    w_hi_next = rs_val;
                        3'd5:    w_lo_next = rs_val;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_cnt_next   = 4'd0;
                    w_busy_next  = 1'b0;
                    w_state_next = S_IDLE;
                    if (!r_op[1]) begin
                        w_hi_next = r_op[0] ? w_prod_u[63:32] : w_prod_s[63:32];
                        w_lo_next = r_op[0] ? w_prod_u[31:0]  : w_prod_s[31:0];
                    end else if (!w_div_zero) begin
                        w_hi_next = w_div_r;
                        w_lo_next = w_div_q;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 2'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_op    <= w_op_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_busy  <= w_busy_next;
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios with literal results plus randomized traffic.
// A cycle-level reference model is compared against the DUT on every falling edge.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on 64-bit integers, independent of any hardware structure.
    function automatic void model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l, output bit w);
        longint x, y, q, r;
        logic [63:0] p;
        w = 1'b1;
        h = 32'd0;
        l = 32'd0;
        x = longint'($signed(a));
        y = longint'($signed(b));
        case (op)
            3'd0: begin p = x * y; h = p[63:32]; l = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
            3'd2: begin
                if (b == 32'd0) w = 1'b0;
                else begin
                    q = x / y; r = x % y;
                    p = q; l = p[31:0];
                    p = r; h = p[31:0];
                end
            end
            default: begin
                if (b == 32'd0) w = 1'b0;
                else begin l = a / b; h = a % b; end
            end
        endcase
    endfunction

    // Reference model state: cycles of busy remaining, architectural HI/LO, pending result.
    int          m_left = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    bit          p_write = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            m_left = 0; m_hi = 32'd0; m_lo = 32'd0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_write) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (start) begin
            if (md_op <= 3'd3) begin
                model_op(md_op, rs_val, rt_val, p_hi, p_lo, p_write);
                m_left = (md_op <= 3'd1) ? 5 : 10;
            end else if (md_op == 3'd4) m_hi = rs_val;
            else if (md_op == 3'd5) m_lo = rs_val;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("cyc_busy", 32'(busy), 32'(m_left > 0));
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op = op; rs_val = a; rt_val = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    function automatic logic [31:0] rand_operand();
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) return 32'd0;
        if (sel == 1) return 32'hFFFFFFFF;
        if (sel == 2) return 32'h80000000;
        if (sel < 6) return 32'($urandom_range(0, 20));
        return $urandom;
    endfunction

    initial begin
        int n;
        // Reset for exactly one edge.
        tick();
        reset = 1'b1;
        checking = 1'b1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        wait_idle(n);
        check("mult_cycles", n, 32'd5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);

        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(n);
        check("multu_cycles", n, 32'd5);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);

        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        check("div_cycles", n, 32'd10);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        issue(3'd3, 32'd7, 32'd0);
        wait_idle(n);
        check("divz_cycles", n, 32'd10);
        check("divz_lo", lo, 32'hFFFFFFFD);
        check("divz_hi", hi, 32'hFFFFFFFF);

        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'h00000000);

        issue(3'd4, 32'h1234, 32'd0);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_busy", 32'(busy), 32'd0);
        issue(3'd0, 32'd6, 32'd7);
        tick();
        issue(3'd5, 32'h55, 32'd0);
        wait_idle(n);
        check("mtlo_ign_cycles", n, 32'd3);
        check("mtlo_ign_lo", lo, 32'd42);
        check("mtlo_ign_hi", hi, 32'd0);

        // Abort a divide with reset in its fourth busy cycle.
        issue(3'd2, 32'd100, 32'd7);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (15) tick();
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);

        // Back-to-back: divu issued in the first idle cycle.
        issue(3'd0, 32'd3, 32'd4);
        wait_idle(n);
        check("b2b_mult_lo", lo, 32'd12);
        issue(3'd3, 32'd100, 32'd7);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_idle(n);
        check("b2b_cycles", n, 32'd10);
        check("b2b_lo", lo, 32'd14);
        check("b2b_hi", hi, 32'd2);

        // Reset wins over a simultaneous start.
        reset = 1'b0;
        issue(3'd0, 32'd2, 32'd3);
        reset = 1'b1;
        check("rst_start_busy", 32'(busy), 32'd0);
        tick();
        check("rst_start_busy2", 32'(busy), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            reset  = ($urandom_range(0, 199) != 0);
            start  = ($urandom_range(0, 2) == 0);
            md_op  = 3'($urandom_range(0, 7));
            rs_val = rand_operand();
            rt_val = rand_operand();
            tick();
        end
        start = 1'b0;
        reset = 1'b1;
        repeat (12) tick();
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of mult/multu in cycles (legal range 1-15).
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of div/divu in cycles (legal range 1-15).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 start  in  1  request strobe; md_op is valid while start=1.
REQ-006 md_op  in  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; codes 6-7 are no-ops.
REQ-007 rs_val  in  32  operand A, already forwarded (dividend / multiplicand / mthi-mtlo source).
REQ-008 rt_val  in  32  operand B (divisor / multiplier).
REQ-009 busy  out  1  operation in progress; EX-stage hazard logic stalls on busy|start.
REQ-010 hi  out  32  HI register, feeds EX result select.
REQ-011 lo  out  32  LO register, feeds EX result select.

Function
REQ-012 Two states, IDLE and BUSY; state change only on a clock edge, with reset=1.
REQ-013 IDLE, start=1, md_op 0-3: latch rs_val/rt_val and op, load counter with MULT_CYCLES (ops 0-1) or DIV_CYCLES (ops 2-3), go to BUSY.
REQ-014 IDLE, start=1, md_op 4: hi<=rs_val next edge; md_op 5: lo<=rs_val next edge; busy stays 0, state stays IDLE.
REQ-015 IDLE, start=1, md_op 6-7: no state change.
REQ-016 BUSY: counter decrements each edge; on the edge where counter==1, write hi/lo, set busy=0, return to IDLE.
REQ-017 busy is registered; high for exactly N cycles following the accepting edge (N = MULT_CYCLES or DIV_CYCLES); new hi/lo visible in the first cycle busy=0.
REQ-018 hi/lo hold old values throughout BUSY; no partial results visible.
REQ-019 start=1 while BUSY is ignored, including mthi/mtlo; the request is not queued.
REQ-020 start=1 in the cycle busy falls (state IDLE) is accepted normally; back-to-back ops carry no dead cycle.
REQ-021 mult: {hi,lo} = signed 32x32 to 64-bit product; multu: unsigned product.
REQ-022 div: lo = quotient truncated toward zero; hi = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-023 div with rs=0x80000000, rt=0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
REQ-024 div/divu with rt=0: full busy duration still runs; hi and lo unchanged at completion.
REQ-025 Operands are taken only from the latch of REQ-013; input changes during BUSY have no effect.

Reset
REQ-026 reset=0 at a rising edge: hi=0, lo=0, busy=0, counter=0, state IDLE.
REQ-027 Reset overrides start in the same cycle.
REQ-028 Reset during BUSY aborts the operation; hi/lo=0, no late write-back.

Verification
REQ-029 reset=0 one edge, then start=1 mult rs=0xFFFFFFFE rt=3 -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-030 multu rs=0xFFFFFFFF rt=0xFFFFFFFF -> after 5 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 div rs=0xFFFFFFF9 (-7) rt=2 -> busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu 7/0 -> hi/lo unchanged after 10 cycles.
REQ-032 mthi rs=0x1234 -> next cycle hi=0x1234, busy never 1. Then mult starts, and mtlo 0x55 arrives in BUSY cycle 2 -> ignored, lo = product.
REQ-033 Start div, assert reset=0 in BUSY cycle 4 -> hi=lo=0, busy=0, no change in any later cycle.
REQ-034 mult completes; start=1 divu issued in the first cycle busy=0 -> busy reasserts next cycle for 10 cycles, with correct results.
